mmu_bus_ctrl: RTL and testbench
===============================

# mmu_bus_ctrl

Parametrised, registered successor to the SoC memory-management/decode unit. It accepts one CPU bus transaction at a time and decodes it against NS base/mask regions. It drives a one-hot slave select with held address, data and direction, then waits for a per-slave acknowledge. It returns read data with a single-cycle `ready`, or raises an error on decode miss or acknowledge timeout, and exposes sticky error-capture status registers.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width; must be ≥ 32.
- `NS`, 5: number of slave channels.
- `SLV_BASE`, {0x0000_C200, 0x0000_C100, 0x0000_C000, 0x0000_8000, 0x0000_0000}: packed NS×AW; slave i at `[i*AW +: AW]`.
- `SLV_MASK`, {0xFFFF_FFF0, 0xFFFF_FFF8, 0xFFFF_FFF8, 0xFFFF_C000, 0xFFFF_8000}: packed NS×AW, same layout.
- `TIMEOUT`, 15: maximum WAIT cycles without an ack; must be ≥ 1.
- `STAT_ADDR`, 0x0000_CF00: status register; STAT_ADDR+4 is the error-address register.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: transaction request; sampled only in IDLE.
- `ADDR` in AW: transaction address.
- `rdWR` in 1: 0 = read, 1 = write.
- `wdata` in DW: write data.
- `rdata` out DW: read data; valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `ready`; 1 = failed transaction.
- `err_irq` out 1: equals the sticky error flag.
- `s_sel` out NS: one-hot slave select.
- `s_we` out 1: held direction.
- `s_addr` out AW: held address.
- `s_wdata` out DW: held write data.
- `s_rdata` in NS×DW: packed slave read data; slave i at `[i*DW +: DW]`.
- `s_ack` in NS: per-slave acknowledge.

## Operation
- Decode: `hit_i = (ADDR & SLV_MASK_i) == SLV_BASE_i`.
  - A match on STAT_ADDR or STAT_ADDR+4 has priority over every slave.
  - Among overlapping slaves, the lowest index wins.
  - No hit is a decode miss.
- FSM states: IDLE, WAIT, RESP.
- IDLE, `req`=1 at an edge:
  - `ADDR`, `rdWR` and `wdata` are latched into `s_addr`, `s_we` and `s_wdata`.
  - Slave hit: `s_sel[i]` is set and the FSM goes to WAIT with the timeout counter cleared.
  - Status hit: the FSM goes to RESP with `err`=0.
    - Read of STAT_ADDR: `rdata` = {err_count[15:0], 14'b0, err_type, err_flag}, zero-extended to DW.
    - Read of STAT_ADDR+4: `rdata` = err_addr.
    - Write of STAT_ADDR with `wdata[0]`=1: clears err_flag, err_type and err_count. err_addr is retained.
    - Write of STAT_ADDR with `wdata[0]`=0, or any write to STAT_ADDR+4: no effect.
  - Decode miss: the FSM goes to RESP with `err`=1 and records the error.
- IDLE, `req`=0: the FSM stays in IDLE.
- WAIT:
  - `s_sel`, `s_we`, `s_addr` and `s_wdata` are held stable.
  - `s_ack[i]`=1 at an edge, where i is the selected slave: a read captures the `s_rdata` slice i into `rdata`; a write leaves `rdata` at 0. `s_sel` clears and the FSM goes to RESP with `err`=0.
  - No ack: the counter increments. If the edge ends the TIMEOUT-th WAIT cycle, `s_sel` clears and the FSM goes to RESP with `err`=1, recording a timeout error.
  - An ack arriving on the final WAIT cycle wins over the timeout.
  - Acks from unselected slaves are ignored.
- RESP:
  - `ready`=1 for exactly one cycle, then the FSM returns to IDLE.
  - `req` is ignored in RESP; a held `req` starts a new transaction at the next IDLE edge.
- Error record:
  - err_flag is set to 1.
  - err_type is 0 for a miss, 1 for a timeout.
  - err_addr is set to the faulting address; the last error wins.
  - err_count increments and saturates at 0xFFFF.
- Reset (asynchronous, including mid-WAIT): `ready`, `err`, `err_irq`, `rdata`, `s_sel`, `s_we`, `s_addr`, `s_wdata`, all counters and all error registers go to 0; FSM goes to IDLE.

## Timing
- Request sampled at edge E0:
  - Miss or status access: `ready` is high during the cycle after E0.
  - Slave access: `s_sel` is high from E0. An ack present at edge E0+k (k ≥ 1) gives `ready` high during the cycle after E0+k.
  - Minimum slave latency is 2 edges.
- On timeout, `s_sel` is high for exactly TIMEOUT cycles.
- `rdata` and `err` are registered and stay valid only while `ready`=1. `rdata` returns to 0 after RESP.
- Issue rate is at most one transaction per 2 cycles (miss/status) or per 3 cycles (slave).

## Test plan
- Read 0x0000_8010; slave 1 acks on the 3rd WAIT cycle with 0xDEAD_BEEF:
  - `s_sel`=5'b00010 for 3 cycles with `s_addr`=0x8010.
  - `ready` pulses 1 cycle, `rdata`=0xDEAD_BEEF, `err`=0.
- Write 0x0000_C004 with 0xA5; slave 2 acks immediately: `s_we`=1, `s_wdata`=0xA5, `s_sel`=5'b00100 for 1 cycle, `ready` with `err`=0.
- Read 0x0001_0000 (miss):
  - `ready`/`err`=1 one cycle after the request; `err_irq`=1.
  - Read of STAT_ADDR returns 0x0001_0001; read of STAT_ADDR+4 returns 0x0001_0000.
- Access 0x0000_C100 with no ack:
  - `s_sel[3]` is high for exactly 15 cycles, then `err`=1.
  - Status reads 0x0002_0003 (after the previous test); err_addr=0x0000_C100.
- Ack on the 15th WAIT cycle: `err`=0, status count unchanged. Write STAT_ADDR with 0x1: status reads 0, `err_irq`=0, err_addr unchanged.
- Assert `rst` mid-WAIT: `s_sel`=0 and `ready`=0 immediately. After release, a read of 0x0000_0004 completes normally and status reads 0.

Source files
------------

// File: rtl/mmu_bus_if.sv
// Bus bundle between the CPU-side requester and mmu_bus_ctrl.
// It carries the CPU transaction signals and the per-slave select, acknowledge and read-data lines.
interface mmu_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NS = 5
);
  logic             req;
  logic [AW-1:0]    ADDR;
  logic             rdWR;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;
  logic             ready;
  logic             err;
  logic             err_irq;
  logic [NS-1:0]    s_sel;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ack;

  modport master (
    output req, ADDR, rdWR, wdata, s_rdata, s_ack,
    input  rdata, ready, err, err_irq, s_sel, s_we, s_addr, s_wdata
  );

  modport slave (
    input  req, ADDR, rdWR, wdata, s_rdata, s_ack,
    output rdata, ready, err, err_irq, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mmu_bus_ctrl.sv
// Registered address decoder and bus sequencer: one CPU transaction at a time, with
// base/mask slave decode, ack timeout and sticky error-capture status registers.
//
// state | meaning
// IDLE  | waiting for req; decodes and latches the request
// WAIT  | slave selected, waiting for its ack or for the timeout
// RESP  | one-cycle ready pulse with rdata/err valid
module mmu_bus_ctrl #(
  parameter int                 AW        = 32,
  parameter int                 DW        = 32,
  parameter int                 NS        = 5,
  parameter logic [NS*AW-1:0]   SLV_BASE  = {32'h0000_C200, 32'h0000_C100, 32'h0000_C000,
                                             32'h0000_8000, 32'h0000_0000},
  parameter logic [NS*AW-1:0]   SLV_MASK  = {32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFF8,
                                             32'hFFFF_C000, 32'hFFFF_8000},
  parameter int                 TIMEOUT   = 15,
  parameter logic [AW-1:0]      STAT_ADDR = AW'(32'h0000_CF00)
) (
  input  logic        clk,
  input  logic        rst,
  mmu_bus_if.slave    bus
);

  localparam int            CW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [AW-1:0] EADDR_ADDR = STAT_ADDR + AW'(4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [NS-1:0]   sel_q, sel_nxt;
  logic            we_q, we_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [DW-1:0]   wdata_q, wdata_nxt;
  logic [DW-1:0]   rdata_q, rdata_nxt;
  logic            ready_q, ready_nxt;
  logic            err_q, err_nxt;
  logic [CW-1:0]   tmo_cnt, tmo_cnt_nxt;
  logic            err_flag, err_flag_nxt;
  logic            err_type, err_type_nxt;
  logic [AW-1:0]   err_addr, err_addr_nxt;
  logic [15:0]     err_count, err_count_nxt;

  logic            slv_hit;
  logic [NS-1:0]   slv_onehot;
  logic            stat_hit, eaddr_hit;
  logic [DW-1:0]   ack_data;
  logic            ack_hit;
  logic            log_err, log_type;
  logic [AW-1:0]   log_addr;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    slv_hit    = 1'b0;
    slv_onehot = '0;
    for (int i = NS-1; i >= 0; i--) begin
      if ((bus.ADDR & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        slv_hit    = 1'b1;
        slv_onehot = NS'(1) << i;
      end
    end
  end

  assign stat_hit  = (bus.ADDR == STAT_ADDR);
  assign eaddr_hit = (bus.ADDR == EADDR_ADDR);
  assign ack_hit   = |(bus.s_ack & sel_q);

  always_comb begin
    ack_data = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q[i]) ack_data = ack_data | bus.s_rdata[i*DW +: DW];
    end
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel_q;
    we_nxt        = we_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    rdata_nxt     = '0;
    ready_nxt     = 1'b0;
    err_nxt       = 1'b0;
    tmo_cnt_nxt   = tmo_cnt;
    err_flag_nxt  = err_flag;
    err_type_nxt  = err_type;
    err_addr_nxt  = err_addr;
    err_count_nxt = err_count;
    log_err       = 1'b0;
    log_type      = 1'b0;
    log_addr      = bus.ADDR;

    case (state)
      IDLE: begin
        if (bus.req) begin
          addr_nxt  = bus.ADDR;
          we_nxt    = bus.rdWR;
          wdata_nxt = bus.wdata;
          if (stat_hit || eaddr_hit) begin
            state_nxt = RESP;
            ready_nxt = 1'b1;
            if (!bus.rdWR) begin
              rdata_nxt = stat_hit ? DW'({err_count, 14'b0, err_type, err_flag})
                                   : DW'(err_addr);
            end else if (stat_hit && bus.wdata[0]) begin
              err_flag_nxt  = 1'b0;
              err_type_nxt  = 1'b0;
              err_count_nxt = '0;
            end
          end else if (slv_hit) begin
            sel_nxt     = slv_onehot;
            tmo_cnt_nxt = CW'(TIMEOUT - 1);
            state_nxt   = WAIT;
          end else begin
            state_nxt = RESP;
            ready_nxt = 1'b1;
            err_nxt   = 1'b1;
            log_err   = 1'b1;
          end
        end
      end
      WAIT: begin
        // An ack on the terminal cycle is checked first so it beats the timeout.
        if (ack_hit) begin
          sel_nxt   = '0;
          state_nxt = RESP;
          ready_nxt = 1'b1;
          if (!we_q) rdata_nxt = ack_data;
        end else if (tmo_cnt == '0) begin
          sel_nxt   = '0;
          state_nxt = RESP;
          ready_nxt = 1'b1;
          err_nxt   = 1'b1;
          log_err   = 1'b1;
          log_type  = 1'b1;
          log_addr  = addr_q;
        end else begin
          tmo_cnt_nxt = tmo_cnt - CW'(1);
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (log_err) begin
      err_flag_nxt = 1'b1;
      err_type_nxt = log_type;
      err_addr_nxt = log_addr;
      if (err_count != 16'hFFFF) err_count_nxt = err_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt   <= '0;
      err_flag  <= 1'b0;
      err_type  <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      sel_q     <= sel_nxt;
      we_q      <= we_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      rdata_q   <= rdata_nxt;
      ready_q   <= ready_nxt;
      err_q     <= err_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      err_flag  <= err_flag_nxt;
      err_type  <= err_type_nxt;
      err_addr  <= err_addr_nxt;
      err_count <= err_count_nxt;
    end
  end

  assign bus.s_sel   = sel_q;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.err_irq = err_flag;

endmodule

// File: tb/tb_mmu_bus_ctrl.sv
// Directed bench for mmu_bus_ctrl: slave hits, misses, timeouts, status registers and reset.
// Expected values are hand-computed from the default decode map.
module tb_mmu_bus_ctrl;

  localparam logic [31:0] STAT  = 32'h0000_CF00;
  localparam logic [31:0] EADDR = 32'h0000_CF04;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mmu_bus_if #(.AW(32), .DW(32), .NS(5)) bus ();

  mmu_bus_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ack_k: WAIT edge (1-based) at which ack_mask is driven, 0 = never; noise is driven on other edges.
  // exp_lat: cycle after the request edge in which ready is expected.
  task automatic run_xact(input string tag, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input int ack_k, input logic [4:0] ack_mask,
                          input logic [4:0] noise, input logic [31:0] rd_word,
                          input logic [4:0] exp_sel, input int exp_sel_cyc,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int  sel_cyc;
    bit  got;
    for (int i = 0; i < 5; i++) begin
      bus.s_rdata[i*32 +: 32] = 32'h5A5A_0000 | 32'(i);
      if (ack_mask[i]) bus.s_rdata[i*32 +: 32] = rd_word;
    end
    bus.req  = 1'b1;
    bus.ADDR = a;
    bus.rdWR = we;
    bus.wdata = wd;
    tick();
    bus.req   = 1'b0;
    bus.ADDR  = 32'hFFFF_FFFF;
    bus.rdWR  = ~we;
    bus.wdata = ~wd;
    sel_cyc = 0;
    got = 1'b0;
    for (int j = 1; j <= 40 && !got; j++) begin
      if (j == 1 && exp_sel != 5'b0) begin
        check_val({tag, "_s_addr"},  bus.s_addr, a);
        check_val({tag, "_s_we"},    32'(bus.s_we), 32'(we));
        check_val({tag, "_s_wdata"}, bus.s_wdata, wd);
      end
      if (bus.s_sel != 5'b0) begin
        if (bus.s_sel == exp_sel) sel_cyc++;
        else check_val({tag, "_s_sel"}, 32'(bus.s_sel), 32'(exp_sel));
      end
      if (bus.ready) begin
        got = 1'b1;
        check_val({tag, "_latency"}, 32'(j), 32'(exp_lat));
        check_val({tag, "_rdata"}, bus.rdata, exp_rdata);
        check_val({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      end else begin
        bus.s_ack = (j == ack_k) ? ack_mask : noise;
        tick();
      end
    end
    bus.s_ack = 5'b0;
    if (!got) check_val({tag, "_ready_seen"}, 32'(got), 32'd1);
    check_val({tag, "_sel_cycles"}, 32'(sel_cyc), 32'(exp_sel_cyc));
    tick();
    check_val({tag, "_ready_drop"}, 32'(bus.ready), 32'd0);
    check_val({tag, "_rdata_drop"}, bus.rdata, 32'd0);
  endtask

  task automatic stat_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    run_xact(tag, a, 1'b0, 32'h0, 0, 5'b0, 5'b0, 32'h0, 5'b0, 0, 1, exp, 1'b0);
  endtask

  task automatic stat_write(input string tag, input logic [31:0] a, input logic [31:0] wd);
    run_xact(tag, a, 1'b1, wd, 0, 5'b0, 5'b0, 32'h0, 5'b0, 0, 1, 32'h0, 1'b0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = 1'b0;
    bus.ADDR = '0;
    bus.rdWR = 1'b0;
    bus.wdata = '0;
    bus.s_rdata = '0;
    bus.s_ack = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check_val("rst_ready",   32'(bus.ready), 32'd0);
    check_val("rst_err",     32'(bus.err), 32'd0);
    check_val("rst_err_irq", 32'(bus.err_irq), 32'd0);
    check_val("rst_s_sel",   32'(bus.s_sel), 32'd0);
    check_val("rst_rdata",   bus.rdata, 32'd0);
    check_val("rst_s_addr",  bus.s_addr, 32'd0);

    run_xact("rd_8010", 32'h0000_8010, 1'b0, 32'h0, 3, 5'b00010, 5'b00001, 32'hDEAD_BEEF,
             5'b00010, 3, 4, 32'hDEAD_BEEF, 1'b0);
    run_xact("wr_c004", 32'h0000_C004, 1'b1, 32'hA5, 1, 5'b00100, 5'b0, 32'h7777_7777,
             5'b00100, 1, 2, 32'h0, 1'b0);

    run_xact("miss_10000", 32'h0001_0000, 1'b0, 32'h0, 0, 5'b0, 5'b0, 32'h0,
             5'b0, 0, 1, 32'h0, 1'b1);
    check_val("miss_irq", 32'(bus.err_irq), 32'd1);
    stat_read("stat_after_miss", STAT, 32'h0001_0001);
    stat_read("eaddr_after_miss", EADDR, 32'h0001_0000);

    run_xact("tmo_c100", 32'h0000_C100, 1'b0, 32'h0, 0, 5'b0, 5'b10111, 32'h0,
             5'b01000, 15, 16, 32'h0, 1'b1);
    stat_read("stat_after_tmo", STAT, 32'h0002_0003);
    stat_read("eaddr_after_tmo", EADDR, 32'h0000_C100);

    run_xact("ack_last", 32'h0000_C104, 1'b0, 32'h0, 15, 5'b01000, 5'b0, 32'h1234_5678,
             5'b01000, 15, 16, 32'h1234_5678, 1'b0);
    stat_read("stat_after_ack_last", STAT, 32'h0002_0003);

    stat_write("wr_stat_0", STAT, 32'h0);
    stat_write("wr_eaddr_1", EADDR, 32'h1);
    stat_read("stat_no_clear", STAT, 32'h0002_0003);
    stat_write("wr_stat_1", STAT, 32'h1);
    stat_read("stat_cleared", STAT, 32'h0);
    check_val("irq_cleared", 32'(bus.err_irq), 32'd0);
    stat_read("eaddr_kept", EADDR, 32'h0000_C100);

    run_xact("rd_c20f", 32'h0000_C20F, 1'b0, 32'h0, 2, 5'b10000, 5'b0, 32'h0BAD_F00D,
             5'b10000, 2, 3, 32'h0BAD_F00D, 1'b0);
    run_xact("miss_c008", 32'h0000_C008, 1'b0, 32'h0, 0, 5'b0, 5'b0, 32'h0,
             5'b0, 0, 1, 32'h0, 1'b1);
    stat_read("stat_c008", STAT, 32'h0001_0001);
    stat_read("eaddr_c008", EADDR, 32'h0000_C008);

    // Held req across RESP: a second miss is accepted only at the following IDLE edge.
    bus.req = 1'b1;
    bus.ADDR = 32'h0002_0000;
    bus.rdWR = 1'b0;
    tick();
    check_val("held_c1_ready", 32'(bus.ready), 32'd1);
    check_val("held_c1_err",   32'(bus.err), 32'd1);
    tick();
    check_val("held_c2_ready", 32'(bus.ready), 32'd0);
    tick();
    check_val("held_c3_ready", 32'(bus.ready), 32'd1);
    bus.req = 1'b0;
    tick();
    check_val("held_c4_ready", 32'(bus.ready), 32'd0);
    stat_read("stat_held", STAT, 32'h0003_0001);
    stat_read("eaddr_held", EADDR, 32'h0002_0000);

    // Asynchronous reset while a slave is selected.
    bus.req = 1'b1;
    bus.ADDR = 32'h0000_C000;
    bus.rdWR = 1'b0;
    tick();
    bus.req = 1'b0;
    check_val("pre_rst_sel", 32'(bus.s_sel), 32'h4);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_val("async_rst_sel",   32'(bus.s_sel), 32'd0);
    check_val("async_rst_ready", 32'(bus.ready), 32'd0);
    check_val("async_rst_addr",  bus.s_addr, 32'd0);
    check_val("async_rst_irq",   32'(bus.err_irq), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_xact("rd_0004", 32'h0000_0004, 1'b0, 32'h0, 2, 5'b00001, 5'b0, 32'hCAFE_0004,
             5'b00001, 2, 3, 32'hCAFE_0004, 1'b0);
    stat_read("stat_after_rst", STAT, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
